rv_elastic_fifo: RTL and testbench
==================================

# rv_elastic_fifo

Ready/valid responder that terminates the upstream ready/valid initiator, buffers accepted beats in a DEPTH-entry FIFO, and re-issues them on a downstream ready/valid port. It sits between the initiator-side interface driven by the `ready_valid_pkg` agent and the DUT datapath. It also gives the bench two observation points: a sticky upstream protocol-violation flag and a wrapping accepted-beat counter.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: payload width; same value as `dut_params_pkg`.
- `DEPTH`, default 4: FIFO entries; power of two, minimum 2.
- `CNT_WIDTH`, default 16: width of the beat counter.

Ports:
- `clk`  input  1  the single clock; all logic on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  upstream beat offered.
- `in_ready`  output  1  upstream beat can be accepted.
- `in_data`  input  DATA_WIDTH  upstream payload.
- `out_valid`  output  1  downstream beat offered.
- `out_ready`  input  1  downstream can accept.
- `out_data`  output  DATA_WIDTH  downstream payload.
- `level`  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `beat_count`  output  CNT_WIDTH  number of accepted upstream beats, modulo 2^CNT_WIDTH.
- `proto_err`  output  1  sticky upstream protocol violation.

## Operation
- Push: occurs when `in_valid && in_ready` at a rising edge. `in_data` is written to `mem[wr_ptr]`, then `wr_ptr` increments modulo DEPTH.
- Pop: occurs when `out_valid && out_ready` at a rising edge. Then `rd_ptr` increments modulo DEPTH.
- `in_ready = (level != DEPTH)`. It is decoded from registered state only and never depends combinationally on `out_ready` or `in_valid`.
- `out_valid = (level != 0)`.
- `out_data = mem[rd_ptr]`. It holds stable while `out_valid && !out_ready`.
- `level` update on each edge:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
- Full with a pop in the same cycle: no push is possible because `in_ready` is low. The pop completes, and `in_ready` rises in the next cycle.
- Empty with a push: no pop occurs. `out_valid` rises in the next cycle, so there is no fall-through.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are distinguished by `level`, not by pointer comparison.
- `beat_count` increments on every push and wraps from 2^CNT_WIDTH-1 to 0.
- Protocol monitor: each cycle, record whether a beat was stalled (`in_valid && !in_ready`) and capture `in_data`. On the next edge, set `proto_err` if a beat was stalled in the previous cycle and either of these holds:
  - `in_valid` is now low, or
  - `in_data` differs from the captured value.
- `proto_err` stays set until reset. Setting it does not block or alter data flow.

## Timing
- Reset (asynchronous assert, synchronous deassert by the environment) clears:
  - `level` = 0, `wr_ptr` = `rd_ptr` = 0
  - `in_ready` = 1, `out_valid` = 0, `out_data` = 0 (memory is cleared)
  - `beat_count` = 0, `proto_err` = 0, stall history cleared
- Latency: a beat pushed at edge N is presented on `out_valid`/`out_data` after edge N when the FIFO was empty. Minimum latency is 1 cycle.
- Throughput: one beat per cycle sustained whenever 0 < `level` < DEPTH, with `out_ready` held high.
- `in_ready` falls in the cycle after the push that makes `level` = DEPTH.
- Reset asserted mid-transfer: all beats held in the FIFO are discarded and the outputs go immediately to their reset values. No beat is emitted for at least one cycle after `rst_n` rises.
- `level`, `beat_count` and `proto_err` are registered and update on the same edge as the event that causes them.

## Test plan
- Single beat, defaults: after reset, push 0xA5 with `out_ready`=1. Required:
  - `out_valid` high for one cycle with `out_data`=0xA5 one cycle after the accept edge.
  - `beat_count` = 1 and `level` returns to 0.
- Fill/drain: hold `out_ready`=0 and offer 0x01..0x05 back-to-back. Required:
  - 4 accepted, and `in_ready` is low after the 4th accept.
  - 0x05 is held stalled upstream and `level` = 4.
  - Raising `out_ready` drains 0x01..0x05 in order, and 0x05 is accepted the cycle after the first pop.
- Simultaneous push/pop at `level`=2, streamed for 20 cycles with both sides high. Required:
  - `level` constant at 2.
  - Output sequence equals input sequence delayed by 2 beats.
  - Pointers wrap 5 times.
- Counter wrap: run with `CNT_WIDTH`=4 and push 17 beats. Required: `beat_count` reads 15, then 0, then 1.
- Protocol error:
  - With the FIFO full, drop `in_valid` while stalled. Required: `proto_err`=1 on the next edge, stays 1, and data flow continues.
  - Repeat after reset, changing `in_data` 0x11→0x22 while stalled. Required: `proto_err`=1.
- Reset mid-operation: with `level`=3, pulse `rst_n` low asynchronously between edges. Required:
  - `out_valid`=0, `in_ready`=1, `level`=0 immediately.
  - The old beats never appear; the first beat after reset is the first one pushed after reset.

Source files
------------

// File: rtl/rv_elastic_fifo.sv
// rv_elastic_fifo: ready/valid elastic FIFO with beat counter and sticky upstream protocol monitor
module rv_elastic_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_WIDTH-1:0]    beat_count,
  output logic                    proto_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  stall_q, stall_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic                  push, pop;
  assign in_ready   = level_q != LW'(DEPTH);
  assign out_valid  = level_q != '0;
  assign out_data   = mem_q[rd_ptr_q];
  assign level      = level_q;
  assign beat_count = cnt_q;
  assign proto_err  = err_q;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  // next-state: storage, pointers, occupancy, counter and stall history
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = in_data;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = (push && !pop) ? level_q + 1'b1 : (pop && !push) ? level_q - 1'b1 : level_q;
    cnt_d    = push ? cnt_q + 1'b1 : cnt_q;
    stall_d  = in_valid && !in_ready;
    cap_d    = in_data;
    err_d    = err_q || (stall_q && (!in_valid || in_data != cap_q));
  end
  // state registers, cleared asynchronously including the storage array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      stall_q  <= 1'b0;
      cap_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      cap_q    <= cap_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_rv_elastic_fifo.sv
// tb_rv_elastic_fifo: directed scoreboard bench for rv_elastic_fifo
module tb_rv_elastic_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, out_valid, proto_err;
  logic [7:0] out_data;
  logic [2:0] level;
  logic [15:0] beat_count;
  logic       in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [7:0] in_data2 = '0;
  logic       in_ready2, out_valid2, proto_err2;
  logic [7:0] out_data2;
  logic [2:0] level2;
  logic [3:0] beat_count2;
  int total = 0, bad = 0;
  logic [7:0] exp_q[$];

  rv_elastic_fifo dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .level(level),
    .beat_count(beat_count), .proto_err(proto_err)
  );

  rv_elastic_fifo #(.CNT_WIDTH(4)) dut_cnt (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .level(level2),
    .beat_count(beat_count2), .proto_err(proto_err2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data = d;
    check("send_ready", in_ready, 1);
    exp_q.push_back(d);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 20 && out_valid; n++) step();
    check("drain_empty", out_valid, 0);
    check("drain_level", level, 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_level", level, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_beat_count", beat_count, 0);
    check("rst_proto_err", proto_err, 0);
    exp_q.delete();
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("post_rst_out_valid", out_valid, 0);
  endtask

  // scoreboard monitor: a pop will happen at the next rising edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got %0h expected none", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          bad++;
          $display("FAIL pop_data: got %0h expected %0h", out_data, e);
        end
      end
    end
  end

  initial begin
    step();
    do_reset();
    // single beat
    out_ready = 1'b1;
    send(8'hA5);
    check("t1_out_valid", out_valid, 1);
    check("t1_level", level, 1);
    check("t1_out_data", out_data, 8'hA5);
    step();
    check("t1_out_valid_low", out_valid, 0);
    check("t1_level0", level, 0);
    check("t1_count", beat_count, 1);
    // fill and drain
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data = 8'(i);
      check("fill_ready", in_ready, 1);
      exp_q.push_back(8'(i));
      step();
    end
    check("fill_level", level, 4);
    check("fill_in_ready", in_ready, 0);
    in_data = 8'h05;
    step();
    check("stall_level", level, 4);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_data", out_data, 8'h01);
    check("stall_proto", proto_err, 0);
    out_ready = 1'b1;
    step();
    check("after_pop_in_ready", in_ready, 1);
    check("after_pop_level", level, 3);
    exp_q.push_back(8'h05);
    step();
    in_valid = 1'b0;
    check("refill_level", level, 3);
    check("fill_count", beat_count, 6);
    drain();
    // streaming at level 2
    out_ready = 1'b0;
    send(8'h30);
    send(8'h31);
    check("stream_pre_level", level, 2);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h32 + i);
      exp_q.push_back(in_data);
      step();
      check("stream_level", level, 2);
    end
    in_valid = 1'b0;
    drain();
    // beat counter wrap on 4-bit instance
    out_ready2 = 1'b1;
    in_valid2 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data2 = 8'(i);
      step();
      if (i >= 14) check("cnt_wrap", beat_count2, (i + 1) % 16);
    end
    in_valid2 = 1'b0;
    // protocol error: valid dropped while stalled
    do_reset();
    for (int i = 0; i < 4; i++) send(8'(8'h40 + i));
    in_valid = 1'b1;
    in_data = 8'h44;
    step();
    check("pe1_before", proto_err, 0);
    in_valid = 1'b0;
    step();
    check("pe1_set", proto_err, 1);
    drain();
    out_ready = 1'b1;
    send(8'h45);
    drain();
    check("pe1_sticky", proto_err, 1);
    // protocol error: data changed while stalled
    do_reset();
    for (int i = 1; i <= 4; i++) send(8'(i));
    in_valid = 1'b1;
    in_data = 8'h11;
    step();
    check("pe2_before", proto_err, 0);
    in_data = 8'h22;
    step();
    in_valid = 1'b0;
    check("pe2_set", proto_err, 1);
    drain();
    // reset mid-operation
    do_reset();
    send(8'h61);
    send(8'h62);
    send(8'h63);
    check("mid_level", level, 3);
    do_reset();
    out_ready = 1'b1;
    send(8'h70);
    drain();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
